dm_block_responder: RTL and testbench
=====================================

// Module: dm_block_responder
// PURPOSE
//  Data-memory responder for the pipeline's data port: serves MEM-stage word reads and sized stores,
//  and 256-bit block read/write requests from a future data cache.
//  Byte-addressed, big-endian backing store with a programmable block-transfer latency.
//  Sits at the memory end of the data-memory interface; the block port feeds the cache refill/writeback path.
// PARAMETERS
//  ADDR_W       16  byte-address bits used; store is 2**ADDR_W bytes; upper address bits ignored
//  BLK_LATENCY  4   cycles from first request-high cycle to valid pulse; legal range 1..255
// PORTS
//  CLK                    in   1    clock, all state on rising edge
//  RESET                  in   1    synchronous, active-high
//  data_address_2DM       in   32   byte address, word and block ports
//  MemRead_2DM            in   1    word read enable
//  MemWrite_2DM           in   1    word store enable
//  data_write_2DM         in   32   store data, right-justified
//  data_write_size_2DM    in   2    store bytes: 1,2,3; 0 = 4
//  data_read_fDM          out  32   word read data
//  dBlkRead               in   1    block read request, level, held until valid
//  dBlkWrite              in   1    block write request, level, held until valid
//  block_write_2DM        in   256  block write data, byte 0 in [255:248]
//  block_read_fDM         out  256  block read data, byte 0 in [255:248]
//  block_read_fDM_valid   out  1    one-cycle pulse, read data ready
//  block_write_fDM_valid  out  1    one-cycle pulse, write committed
// BEHAVIOUR
//  Reset
//   - FSM -> IDLE; counter = 0; block_read_fDM = 0; both valids = 0.
//   - Store contents not cleared; the simulator preloads them.
//   - RESET mid-transfer aborts it: no pulse, no commit.
//  Word port (independent of block FSM, never stalls)
//   - data_read_fDM is combinational: bytes A..A+3 (mod store size), big-endian, when MemRead_2DM=1; else 0.
//   - Store at edge when MemWrite_2DM=1, n = size (0 -> 4).
//   - Byte A+k <= data_write_2DM[8*(n-1-k)+:8] for k = 0..n-1; addresses wrap mod 2**ADDR_W.
//   - Read and write in the same cycle: read returns pre-store data.
//  Block port
//   - Block base = address with bits [4:0] cleared; 32 bytes.
//   - IDLE: on dBlkWrite (priority over dBlkRead if both high) -> WR_WAIT; else on dBlkRead -> RD_WAIT.
//     Counter loads BLK_LATENCY-1 and the base address is latched.
//   - WR_WAIT/RD_WAIT: counter decrements each cycle. When the counter is 0 at an edge -> RESP, and:
//       RD: block_read_fDM <= 32 bytes at latched base; block_read_fDM_valid=1 for the RESP cycle.
//       WR: store <= block_write_2DM at latched base; block_write_fDM_valid=1 for the RESP cycle.
//   - Latency: request first high in cycle 0 -> valid high in cycle BLK_LATENCY.
//   - Request deasserted during *_WAIT -> IDLE: no pulse, no store change.
//   - RESP -> DRAIN, or IDLE if the active request is already low.
//     DRAIN holds until both requests are low, then -> IDLE.
//     A held request is never serviced twice; minimum 1 idle cycle between transfers.
//   - block_read_fDM holds its value until the next completed block read.
//   - Address or write-data changes during WAIT: the latched base is used; write data is sampled at the commit edge.
//   - Word store and block-write commit on the same edge, overlapping bytes: word store wins.
//   - A word read in the commit cycle sees pre-commit data.
// TESTING
//  - Reset with store preloaded 0x0..: outputs 0, FSM IDLE, memory intact.
//  - Stores:
//      sw 0x11223344 @0x100.
//      sb 0xAA @0x101 -> lw @0x100 = 0x11AA3344.
//      sh 0xBEEF @0x102 -> lw @0x100 = 0x11AABEEF.
//  - BLK_LATENCY=4, dBlkRead @0x10F from cycle 0:
//      block_read_fDM_valid pulses only in cycle 4.
//      block_read_fDM = bytes 0x100..0x11F.
//      Request held to cycle 6 -> no second pulse.
//  - dBlkRead and dBlkWrite both high: write serviced first; block_write_fDM_valid in cycle 4.
//    Subsequent lw shows the new data.
//  - dBlkWrite dropped in cycle 2: no valid pulse, memory unchanged.
//    RESET asserted in cycle 3 of a read: no pulse.
//  - Same-edge collision: block-write commit plus sw 0xDEADBEEF @base -> word = 0xDEADBEEF, other 28 bytes from block.

Source files
------------

// File: rtl/dm_block_responder.sv
// rtl/dm_block_responder.sv - data-memory responder with word port and latency-controlled 256-bit block port
//
// Purpose: byte-addressed big-endian backing store. It serves MEM-stage word
// reads and sized stores, and 32-byte block read/write transfers for a data
// cache refill/writeback path.
//
// Ports:
//   CLK, RESET             clock, synchronous active-high reset
//   data_address_2DM       byte address shared by the word and block ports
//   MemRead_2DM            word read enable; data_read_fDM is combinational
//   MemWrite_2DM           word store enable
//   data_write_2DM         store data, right-justified
//   data_write_size_2DM    store byte count 1..3, 0 means 4
//   data_read_fDM          word read data, 0 when MemRead_2DM is low
//   dBlkRead, dBlkWrite    level block requests, held until the valid pulse
//   block_write_2DM        block write data, byte 0 in [255:248]
//   block_read_fDM         last completed block read, byte 0 in [255:248]
//   block_read_fDM_valid   one-cycle pulse when block read data is ready
//   block_write_fDM_valid  one-cycle pulse when a block write has committed
module dm_block_responder #(
  parameter int ADDR_W      = 16,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);

  localparam int       MEM_BYTES = 1 << ADDR_W;
  localparam logic [7:0] LAT_M1  = 8'(BLK_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, RESP, DRAIN} state_t;

  logic [7:0] mem [MEM_BYTES];

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                is_wr_q, is_wr_d;
  logic [255:0]        blk_rd_q, blk_rd_d;

  logic [ADDR_W-1:0]   word_a;
  logic [ADDR_W-1:0]   req_base;
  logic [ADDR_W-1:0]   commit_base;
  logic [7:0]          cnt_dec;
  logic                commit_rd;
  logic                commit_wr;
  logic [2:0]          st_n;
  logic [31:0]         st_aligned;
  logic                unused_addr_hi;

  assign word_a         = data_address_2DM[ADDR_W-1:0];
  assign req_base       = {word_a[ADDR_W-1:5], 5'b0};
  assign unused_addr_hi = ^data_address_2DM[31:ADDR_W];
  assign cnt_dec        = cnt_q - 8'd1;

  // With a latency of 1 the commit happens on the edge leaving IDLE, before
  // the base has been latched, so take it straight from the address bus.
  assign commit_base = (state_q == IDLE) ? req_base : base_q;

  // Store byte count and the store data shifted so byte A is always in [31:24].
  assign st_n       = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
  assign st_aligned = data_write_2DM << {(3'd4 - st_n), 3'b000};

  always_comb begin
    data_read_fDM = '0;
    if (MemRead_2DM) begin
      for (int k = 0; k < 4; k++) begin
        data_read_fDM[31-8*k -: 8] = mem[word_a + ADDR_W'(k)];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    is_wr_d   = is_wr_q;
    blk_rd_d  = blk_rd_q;
    commit_rd = 1'b0;
    commit_wr = 1'b0;

    case (state_q)
      IDLE: begin
        if (dBlkWrite || dBlkRead) begin
          is_wr_d = dBlkWrite;
          base_d  = req_base;
          cnt_d   = LAT_M1;
          if (LAT_M1 == 8'd0) begin
            state_d   = RESP;
            commit_wr = dBlkWrite;
            commit_rd = !dBlkWrite;
          end else begin
            state_d = dBlkWrite ? WR_WAIT : RD_WAIT;
          end
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_dec;
        if (!dBlkWrite) begin
          state_d = IDLE;
        end else if (cnt_dec == 8'd0) begin
          state_d   = RESP;
          commit_wr = 1'b1;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_dec;
        if (!dBlkRead) begin
          state_d = IDLE;
        end else if (cnt_dec == 8'd0) begin
          state_d   = RESP;
          commit_rd = 1'b1;
        end
      end
      RESP: begin
        state_d = (is_wr_q ? dBlkWrite : dBlkRead) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!dBlkWrite && !dBlkRead) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit_rd) begin
      for (int i = 0; i < 32; i++) begin
        blk_rd_d[255-8*i -: 8] = mem[commit_base + ADDR_W'(i)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      is_wr_q  <= 1'b0;
      blk_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      is_wr_q  <= is_wr_d;
      blk_rd_q <= blk_rd_d;
    end
  end

  // The storage array is written in place. The word store comes after the
  // block commit so that it wins on overlapping bytes.
  always_ff @(posedge CLK) begin
    if (commit_wr && !RESET) begin
      for (int i = 0; i < 32; i++) begin
        mem[commit_base + ADDR_W'(i)] <= block_write_2DM[255-8*i -: 8];
      end
    end
    if (MemWrite_2DM) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < st_n) mem[word_a + ADDR_W'(k)] <= st_aligned[31-8*k -: 8];
      end
    end
  end

  assign block_read_fDM        = blk_rd_q;
  assign block_read_fDM_valid  = (state_q == RESP) && !is_wr_q;
  assign block_write_fDM_valid = (state_q == RESP) && is_wr_q;

endmodule

// File: tb/tb_dm_block_responder.sv
// tb/tb_dm_block_responder.sv - directed vector bench for dm_block_responder
module tb_dm_block_responder;

  logic         CLK;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;

  int checks   = 0;
  int failures = 0;

  dm_block_responder #(.ADDR_W(16), .BLK_LATENCY(4)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DM      (data_address_2DM),
    .MemRead_2DM           (MemRead_2DM),
    .MemWrite_2DM          (MemWrite_2DM),
    .data_write_2DM        (data_write_2DM),
    .data_write_size_2DM   (data_write_size_2DM),
    .data_read_fDM         (data_read_fDM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] exp;
  } wvec_t;

  wvec_t tv[14];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string nm);
    MemRead_2DM      = 1'b1;
    data_address_2DM = a;
    #1;
    chk(nm, {224'd0, data_read_fDM}, {224'd0, exp});
    MemRead_2DM = 1'b0;
  endtask

  logic [255:0] exp_a, exp_e, bw;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; data_address_2DM = '0; MemRead_2DM = 1'b0; MemWrite_2DM = 1'b0;
    data_write_2DM = '0; data_write_size_2DM = '0; dBlkRead = 1'b0; dBlkWrite = 1'b0;
    block_write_2DM = '0;
    for (int i = 0; i < 65536; i++) dut.mem[i] = i[7:0];

    //        mr    mw    addr          wdata          sz     expected read
    tv[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2'd0, 32'h0001_0203};
    tv[1]  = '{1'b1, 1'b0, 32'h0001_0104, 32'h0,         2'd0, 32'h0405_0607};
    tv[2]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         2'd0, 32'h0};
    tv[3]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h1122_3344, 2'd0, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd0, 32'h1122_3344};
    tv[5]  = '{1'b0, 1'b1, 32'h0000_0101, 32'h0000_00AA, 2'd1, 32'h0};
    tv[6]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd0, 32'h11AA_3344};
    tv[7]  = '{1'b0, 1'b1, 32'h0000_0102, 32'h0000_BEEF, 2'd2, 32'h0};
    tv[8]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd0, 32'h11AA_BEEF};
    tv[9]  = '{1'b1, 1'b1, 32'h0000_0300, 32'h00AB_CDEF, 2'd3, 32'h0001_0203};
    tv[10] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         2'd0, 32'hABCD_EF03};
    tv[11] = '{1'b1, 1'b1, 32'h0000_FFFE, 32'hCAFE_F00D, 2'd0, 32'hFEFF_0001};
    tv[12] = '{1'b1, 1'b0, 32'h0000_FFFE, 32'h0,         2'd0, 32'hCAFE_F00D};
    tv[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2'd0, 32'hF00D_0203};

    tick(); tick();
    RESET = 1'b0;
    chk("reset_rd_valid", {255'd0, block_read_fDM_valid}, 256'd0);
    chk("reset_wr_valid", {255'd0, block_write_fDM_valid}, 256'd0);
    chk("reset_blk_rd", block_read_fDM, 256'd0);

    // word port vectors
    for (int v = 0; v < 14; v++) begin
      MemRead_2DM = tv[v].mr; MemWrite_2DM = tv[v].mw; data_address_2DM = tv[v].addr;
      data_write_2DM = tv[v].wd; data_write_size_2DM = tv[v].sz;
      #1;
      chk($sformatf("word_vec%0d", v), {224'd0, data_read_fDM}, {224'd0, tv[v].exp});
      tick();
    end
    MemRead_2DM = 1'b0; MemWrite_2DM = 1'b0;
    tick();

    // block read at 0x10F, address moved mid-wait, request held through cycle 6
    for (int i = 0; i < 32; i++) exp_a[255-8*i -: 8] = 8'(16'h100 + i);
    exp_a[255:224] = 32'h11AA_BEEF;
    dBlkRead = 1'b1; data_address_2DM = 32'h0000_010F;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) data_address_2DM = 32'h0000_0500;
      #1;
      chk($sformatf("rdA_valid_c%0d", c), {255'd0, block_read_fDM_valid}, {255'd0, c == 4});
      chk($sformatf("rdA_wvalid_c%0d", c), {255'd0, block_write_fDM_valid}, 256'd0);
      if (c == 4 || c == 6) chk($sformatf("rdA_data_c%0d", c), block_read_fDM, exp_a);
      tick();
    end
    dBlkRead = 1'b0;
    tick();

    // both requests high: write wins; data sampled at commit edge
    for (int i = 0; i < 32; i++) bw[255-8*i -: 8] = 8'(8'hA0 + i);
    dBlkRead = 1'b1; dBlkWrite = 1'b1; data_address_2DM = 32'h0000_0400;
    block_write_2DM = {32{8'h33}};
    for (int c = 0; c < 7; c++) begin
      if (c == 3) block_write_2DM = bw;
      #1;
      chk($sformatf("wrB_wvalid_c%0d", c), {255'd0, block_write_fDM_valid}, {255'd0, c == 4});
      chk($sformatf("wrB_rvalid_c%0d", c), {255'd0, block_read_fDM_valid}, 256'd0);
      tick();
    end
    dBlkRead = 1'b0; dBlkWrite = 1'b0;
    tick();
    chk("wrB_blk_rd_held", block_read_fDM, exp_a);
    lw(32'h0000_0400, 32'hA0A1_A2A3, "wrB_lw400");
    lw(32'h0000_041C, 32'hBCBD_BEBF, "wrB_lw41C");

    // write request dropped in cycle 2
    dBlkWrite = 1'b1; data_address_2DM = 32'h0000_0600; block_write_2DM = {32{8'hFF}};
    for (int c = 0; c < 7; c++) begin
      if (c == 2) dBlkWrite = 1'b0;
      #1;
      chk($sformatf("dropC_wvalid_c%0d", c), {255'd0, block_write_fDM_valid}, 256'd0);
      tick();
    end
    lw(32'h0000_0600, 32'h0001_0203, "dropC_lw600");
    lw(32'h0000_061C, 32'h1C1D_1E1F, "dropC_lw61C");

    // reset asserted in cycle 3 of a read
    dBlkRead = 1'b1; data_address_2DM = 32'h0000_0700;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin RESET = 1'b1; dBlkRead = 1'b0; end
      if (c == 4) RESET = 1'b0;
      #1;
      chk($sformatf("rstD_valid_c%0d", c), {255'd0, block_read_fDM_valid}, 256'd0);
      tick();
    end
    chk("rstD_blk_rd_cleared", block_read_fDM, 256'd0);
    lw(32'h0000_0100, 32'h11AA_BEEF, "rstD_mem_intact");

    // same-edge collision: block write commit with a word store at the base
    for (int i = 0; i < 32; i++) bw[255-8*i -: 8] = 8'(8'h50 + i);
    exp_e = bw;
    exp_e[255:224] = 32'hDEAD_BEEF;
    dBlkWrite = 1'b1; data_address_2DM = 32'h0000_0800; block_write_2DM = bw;
    for (int c = 0; c < 6; c++) begin
      MemWrite_2DM = (c == 3); data_write_2DM = 32'hDEAD_BEEF; data_write_size_2DM = 2'd0;
      if (c == 5) dBlkWrite = 1'b0;
      #1;
      chk($sformatf("colE_wvalid_c%0d", c), {255'd0, block_write_fDM_valid}, {255'd0, c == 4});
      tick();
    end
    MemWrite_2DM = 1'b0;
    tick();
    lw(32'h0000_0800, 32'hDEAD_BEEF, "colE_lw800");
    lw(32'h0000_0804, 32'h5455_5657, "colE_lw804");
    dBlkRead = 1'b1; data_address_2DM = 32'h0000_0800;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 4) begin
        chk("colE_rd_valid", {255'd0, block_read_fDM_valid}, {255'd0, 1'b1});
        chk("colE_blk", block_read_fDM, exp_e);
      end
      tick();
    end
    dBlkRead = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
